// File: rtl/shift_capture_pkg.sv
// Shared definitions for the shift/capture controller that sits behind the
// RF-in synchroniser FSM.
//   state_e       : controller FSM encoding (S_IDLE .. S_RELEASE)
//   *_DEF         : default parameter values
//   clog2()       : ceiling log2, used to size the bit counter
package shift_capture_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DELAY   = 3'd1,
      S_SHIFT   = 3'd2,
      S_DONE    = 3'd3,
      S_RELEASE = 3'd4
   } state_e;

   localparam int DATA_W_DEF      = 8;
   localparam int START_DLY_DEF   = 2;
   localparam int REL_TIMEOUT_DEF = 4;
   localparam int CNT8_W          = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_capture_sreg.sv
// MSB-first serial-to-parallel shift register with a saturating bit counter.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   en_i          : shift this cycle (high for the whole window)
//   sdin_i        : serial data bit
//   word_nxt_o    : register contents including this cycle's bit
//   done_o        : this cycle samples the last bit of the window
// The counter clears whenever en_i is low, so every window starts at bit 0.
module shift_capture_sreg
   import shift_capture_pkg::*;
#(
   parameter int WIN   = 8,
   parameter int CNT_W = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_i,
   input  logic           sdin_i,
   output logic [WIN-1:0] word_nxt_o,
   output logic           done_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

   logic [WIN-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign word_nxt_o = {shreg_q[WIN-2:0], sdin_i};
   assign done_o     = en_i && (cnt_q == CNT_LAST);

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = '0;
      if (en_i) begin
         shreg_d = word_nxt_o;
         cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_capture_ctrl.sv
// Shift/capture controller downstream of the RF-in synchroniser.
// On a rising edge of the synchroniser state it waits START_DLY cycles, opens
// the sh_en window, shifts sdin into a word (MSB first) and presents it with a
// one-cycle data_valid. The falling edge of sh_en releases the synchroniser;
// if it stays ACTIVE for REL_TIMEOUT cycles a one-cycle fsm_rst is issued.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   sync_state_i   : synchroniser state (0 IDLE, 1 ACTIVE)
//   sdin_i         : serial data, sampled while sh_en_o=1
//   sh_en_o        : shift window, fed back to the synchroniser
//   fsm_rst_o      : one-cycle forced release of the synchroniser
//   data_out_o     : last captured word
//   data_valid_o   : one-cycle strobe with a new data_out_o
//   abort_o        : one-cycle pulse when a window is abandoned
//   busy_o         : controller not idle
//   parity_err_o   : only with SHIFT_CAPTURE_PARITY_EN; window grows by one
//                    even-parity bit, flag valid with data_valid_o
// All outputs are registered from the next-state decode, so they line up
// with the state they describe.
module shift_capture_ctrl
   import shift_capture_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int START_DLY   = START_DLY_DEF,
   parameter int REL_TIMEOUT = REL_TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sync_state_i,
   input  logic              sdin_i,
   output logic              sh_en_o,
   output logic              fsm_rst_o,
   output logic [DATA_W-1:0] data_out_o,
   output logic              data_valid_o,
   output logic              abort_o,
   output logic              busy_o
`ifdef SHIFT_CAPTURE_PARITY_EN
   ,
   output logic              parity_err_o
`endif
);

`ifdef SHIFT_CAPTURE_PARITY_EN
   localparam int WIN = DATA_W + 1;
`else
   localparam int WIN = DATA_W;
`endif
   localparam int CNT_W = clog2(DATA_W + 1);
   localparam logic [CNT8_W-1:0] DLY_LOAD = CNT8_W'(START_DLY > 0 ? START_DLY - 1 : 0);
   localparam logic [CNT8_W-1:0] TO_LAST  = CNT8_W'(REL_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                sync_prev_q, sync_prev_d;
   logic [CNT8_W-1:0]   dly_cnt_q, dly_cnt_d;
   logic [CNT8_W-1:0]   to_cnt_q, to_cnt_d, to_inc;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                sh_en_q, fsm_rst_q, fsm_rst_d;
   logic                valid_q, valid_d, abort_q, abort_d, busy_q;
   logic                start;
   logic [WIN-1:0]      word_nxt;
   logic                last_bit;
   logic [DATA_W-1:0]   cap_word;
`ifdef SHIFT_CAPTURE_PARITY_EN
   logic                perr_q, perr_d;
`endif

   shift_capture_sreg #(
      .WIN   (WIN),
      .CNT_W (CNT_W)
   ) u_sreg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (state_q == S_SHIFT),
      .sdin_i     (sdin_i),
      .word_nxt_o (word_nxt),
      .done_o     (last_bit)
   );

   // The parity bit arrives last, so it sits in the LSB of the window.
`ifdef SHIFT_CAPTURE_PARITY_EN
   assign cap_word = word_nxt[WIN-1:1];
`else
   assign cap_word = word_nxt;
`endif

   assign start  = sync_state_i & ~sync_prev_q;
   assign to_inc = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      sync_prev_d = sync_state_i;
      dly_cnt_d   = dly_cnt_q;
      to_cnt_d    = to_cnt_q;
      data_out_d  = data_out_q;
      fsm_rst_d   = 1'b0;
      valid_d     = 1'b0;
      abort_d     = 1'b0;
`ifdef SHIFT_CAPTURE_PARITY_EN
      perr_d      = perr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (START_DLY == 0) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d   = S_DELAY;
                  dly_cnt_d = DLY_LOAD;
               end
            end
         end
         S_DELAY: begin
            // losing the synchroniser wins over an expiring count
            if (!sync_state_i) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else if (dly_cnt_q == '0) begin
               state_d = S_SHIFT;
            end else begin
               dly_cnt_d = dly_cnt_q - 1'b1;
            end
         end
         S_SHIFT: begin
            // the last bit completes even if the synchroniser already dropped
            if (last_bit) begin
               state_d    = S_DONE;
               data_out_d = cap_word;
               valid_d    = 1'b1;
`ifdef SHIFT_CAPTURE_PARITY_EN
               perr_d     = ^word_nxt;
`endif
            end else if (!sync_state_i) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d  = S_RELEASE;
            to_cnt_d = '0;
         end
         S_RELEASE: begin
            if (!sync_state_i) begin
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_inc;
               if (to_inc >= TO_LAST) begin
                  fsm_rst_d   = 1'b1;
                  state_d     = S_IDLE;
                  // the level is still high: do not let IDLE see it as a new edge
                  sync_prev_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         sync_prev_q <= 1'b0;
         dly_cnt_q   <= '0;
         to_cnt_q    <= '0;
         data_out_q  <= '0;
         sh_en_q     <= 1'b0;
         fsm_rst_q   <= 1'b0;
         valid_q     <= 1'b0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SHIFT_CAPTURE_PARITY_EN
         perr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync_prev_q <= sync_prev_d;
         dly_cnt_q   <= dly_cnt_d;
         to_cnt_q    <= to_cnt_d;
         data_out_q  <= data_out_d;
         sh_en_q     <= (state_d == S_SHIFT);
         fsm_rst_q   <= fsm_rst_d;
         valid_q     <= valid_d;
         abort_q     <= abort_d;
         busy_q      <= (state_d != S_IDLE);
`ifdef SHIFT_CAPTURE_PARITY_EN
         perr_q      <= perr_d;
`endif
      end
   end

   assign sh_en_o      = sh_en_q;
   assign fsm_rst_o    = fsm_rst_q;
   assign data_out_o   = data_out_q;
   assign data_valid_o = valid_q;
   assign abort_o      = abort_q;
   assign busy_o       = busy_q;
`ifdef SHIFT_CAPTURE_PARITY_EN
   assign parity_err_o = perr_q;
`endif

endmodule
